game_scheduler: RTL

- Round controller for the LED/switch reaction game.
- Runs a timed round, periodically picks a pseudo-random idle LED and issues a one-cycle led_request/led_index pulse to the LED/switch datapath.
- Uses the datapath's leds bus as feedback so it never targets an LED that is already lit.
- Exposes round status (active, over, seconds left) to the display logic.

---
 rtl/game_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/game_scheduler.sv
// game_scheduler: round controller for the LED/switch reaction game.
// Times a round, spawns one pseudo-random idle LED per interval and reports round status.
// Ports:
//   clk, rst_n (async active-low)  start (level)  leds_active[NUM_LEDS] (LED feedback)
//   led_request/led_index (1-cycle spawn)  game_active, game_over, time_left[8]
module game_scheduler #(
  parameter int          CLK_PERIOD_NS = 50,
  parameter int          SPAWN_MS      = 1000,
  parameter int          GAME_SEC      = 30,
  parameter int          NUM_LEDS      = 18,
  parameter int          MAX_TRIES     = 8,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NUM_LEDS-1:0] leds_active,
  output logic                led_request,
  output logic [4:0]          led_index,
  output logic                game_active,
  output logic                game_over,
  output logic [7:0]          time_left
);

  localparam longint SEC_RAW =
    longint'(1_000_000_000) / longint'(CLK_PERIOD_NS);
  localparam longint SPN_RAW =
    longint'(SPAWN_MS) * 1_000_000 / longint'(CLK_PERIOD_NS);
  localparam longint SEC_CYC = (SEC_RAW < 1) ? 1 : SEC_RAW;
  localparam longint SPN_CYC = (SPN_RAW < 2) ? 2 : SPN_RAW;

  localparam int SEC_W = (SEC_CYC > 1) ? $clog2(SEC_CYC) : 1;
  localparam int SPN_W = $clog2(SPN_CYC);
  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_CYC - 1);
  localparam logic [SPN_W-1:0] SPN_LAST = SPN_W'(SPN_CYC - 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
  localparam logic [7:0]       GS8      = 8'(GAME_SEC);
  localparam logic [5:0]       NL6      = 6'(NUM_LEDS);

  // an all-zero seed would lock the LFSR
  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_PICK,
    S_OVER
  } state_t;

  state_t           r_state;
  logic [15:0]      r_lfsr;
  logic [SEC_W-1:0] r_sec_cnt;
  logic [SPN_W-1:0] r_spn_cnt;
  logic [TRY_W-1:0] r_tries;
  logic [7:0]       r_time_left;
  logic             r_led_request;
  logic [4:0]       r_led_index;
  logic             r_game_active;
  logic             r_game_over;

  state_t           w_state_nx;
  logic [15:0]      w_lfsr_nx;
  logic [SEC_W-1:0] w_sec_nx;
  logic [SPN_W-1:0] w_spn_nx;
  logic [TRY_W-1:0] w_try_nx;
  logic [7:0]       w_time_nx;
  logic             w_req_nx;
  logic [4:0]       w_idx_nx;

  logic [31:0]      w_leds;
  logic [4:0]       w_cand;
  logic             w_cand_ok;
  logic             w_sec_wrap;
  logic             w_spn_wrap;
  logic             w_expire;

  assign w_lfsr_nx = {1'b0, r_lfsr[15:1]}
                   ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  // widened copy so out-of-range candidates never index past the bus
  assign w_leds    = 32'(leds_active);
  assign w_cand    = r_lfsr[4:0];
  assign w_cand_ok = ({1'b0, w_cand} < NL6) && !w_leds[w_cand];

  assign w_sec_wrap = (r_sec_cnt == SEC_LAST);
  assign w_spn_wrap = (r_spn_cnt == SPN_LAST);
  // the last second ending beats any spawn or pick on the same edge
  assign w_expire   = w_sec_wrap && (r_time_left <= 8'd1);

  always_comb begin
    w_state_nx = r_state;
    w_sec_nx   = r_sec_cnt;
    w_spn_nx   = r_spn_cnt;
    w_try_nx   = r_tries;
    w_time_nx  = r_time_left;
    w_req_nx   = 1'b0;
    w_idx_nx   = 5'd0;
    unique case (r_state)
      S_IDLE, S_OVER: begin
        if (start) begin
          w_state_nx = S_PLAY;
          w_time_nx  = GS8;
          w_sec_nx   = '0;
          w_spn_nx   = '0;
          w_try_nx   = '0;
        end
      end
      S_PLAY, S_PICK: begin
        w_sec_nx = w_sec_wrap ? '0 : r_sec_cnt + SEC_W'(1);
        if (w_expire) begin
          w_state_nx = S_OVER;
          w_time_nx  = 8'd0;
          w_spn_nx   = '0;
          w_try_nx   = '0;
        end else begin
          if (w_sec_wrap) begin
            w_time_nx = r_time_left - 8'd1;
          end
          if (r_state == S_PLAY) begin
            if (w_spn_wrap) begin
              w_state_nx = S_PICK;
              w_spn_nx   = '0;
              w_try_nx   = '0;
            end else begin
              w_spn_nx = r_spn_cnt + SPN_W'(1);
            end
          end else if (w_cand_ok) begin
            w_req_nx   = 1'b1;
            w_idx_nx   = w_cand;
            w_state_nx = S_PLAY;
            w_spn_nx   = '0;
            w_try_nx   = '0;
          end else if (r_tries == TRY_LAST) begin
            // every attempt hit a lit or invalid LED: skip this spawn
            w_state_nx = S_PLAY;
            w_spn_nx   = '0;
            w_try_nx   = '0;
          end else begin
            w_try_nx = r_tries + TRY_W'(1);
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_lfsr        <= SEED;
      r_sec_cnt     <= '0;
      r_spn_cnt     <= '0;
      r_tries       <= '0;
      r_time_left   <= 8'd0;
      r_led_request <= 1'b0;
      r_led_index   <= 5'd0;
      r_game_active <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_lfsr        <= w_lfsr_nx;
      r_sec_cnt     <= w_sec_nx;
      r_spn_cnt     <= w_spn_nx;
      r_tries       <= w_try_nx;
      r_time_left   <= w_time_nx;
      r_led_request <= w_req_nx;
      r_led_index   <= w_idx_nx;
      r_game_active <= (w_state_nx == S_PLAY)
                    || (w_state_nx == S_PICK);
      r_game_over   <= (w_state_nx == S_OVER);
    end
  end

  assign led_request = r_led_request;
  assign led_index   = r_led_index;
  assign game_active = r_game_active;
  assign game_over   = r_game_over;
  assign time_left   = r_time_left;

endmodule
